// File: rtl/inst_fetch_queue_pkg.sv
// Shared types for the instruction fetch queue: fetch FSM state encoding.
package inst_fetch_queue_pkg;

  typedef enum logic [1:0] {
    FQ_IDLE = 2'd0,
    FQ_WAIT = 2'd1,
    FQ_DROP = 2'd2
  } fq_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding {pc, instruction} pairs; head is read straight from registers.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_clear,
  input  logic [WIDTH-1:0]           i_din,
  output logic [WIDTH-1:0]           o_dout,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W:0]     r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch stage: single-outstanding memory read FSM feeding a small {pc, inst} FIFO to decode.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              ce_i,
  output logic              pc_ready_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              flush_i,
  output logic              id_valid_o,
  input  logic              id_ready_i,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [DATA_W-1:0] id_inst_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  fq_state_e                  r_state;
  fq_state_e                  w_state_nxt;
  logic [ADDR_W-1:0]          r_pend_pc;
  logic [CNT_W-1:0]           w_count;
  logic [ADDR_W+DATA_W-1:0]   w_head;
  logic                       w_rsp;
  logic                       w_slot_ok;
  logic                       w_req;
  logic                       w_grant;
  logic                       w_push;
  logic                       w_pop;

  assign w_rsp     = (r_state == FQ_WAIT) & mem_rvalid_i;
  // Pop is deliberately ignored here so a full FIFO can never be overrun.
  assign w_slot_ok = ({1'b0, w_count} + (CNT_W+1)'(w_rsp)) < (CNT_W+1)'(DEPTH);
  assign w_req     = ce_i & ~flush_i & ~rst & w_slot_ok & ((r_state == FQ_IDLE) | w_rsp);
  assign w_grant   = w_req & mem_gnt_i;
  assign w_push    = w_rsp & ~flush_i;
  assign w_pop     = id_valid_o & id_ready_i & ~flush_i;

  assign mem_req_o  = w_req;
  assign pc_ready_o = w_grant;
  assign mem_addr_o = pc_i;
  assign id_valid_o = (w_count != '0);
  assign id_pc_o    = w_head[ADDR_W+DATA_W-1:DATA_W];
  assign id_inst_o  = w_head[DATA_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= FQ_IDLE;
      r_pend_pc <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_pend_pc <= pc_i;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FQ_IDLE: begin
        if (w_grant) w_state_nxt = FQ_WAIT;
      end
      FQ_WAIT: begin
        if (flush_i)           w_state_nxt = mem_rvalid_i ? FQ_IDLE : FQ_DROP;
        else if (mem_rvalid_i) w_state_nxt = w_grant ? FQ_WAIT : FQ_IDLE;
      end
      FQ_DROP: begin
        if (mem_rvalid_i) w_state_nxt = FQ_IDLE;
      end
      default: w_state_nxt = FQ_IDLE;
    endcase
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_W + DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (flush_i),
    .i_din   ({r_pend_pc, mem_rdata_i}),
    .o_dout  (w_head),
    .o_count (w_count)
  );

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: directed scenarios then random traffic vs a queue model.
module tb_inst_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        ce_i;
  logic        pc_ready_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        flush_i;
  logic        id_valid_o;
  logic        id_ready_i;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;

  inst_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_i         (pc_i),
    .ce_i         (ce_i),
    .pc_ready_o   (pc_ready_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .flush_i      (flush_i),
    .id_valid_o   (id_valid_o),
    .id_ready_i   (id_ready_i),
    .id_pc_o      (id_pc_o),
    .id_inst_o    (id_inst_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_ready = 0;
  bit seen_dead = 1'b0;

  // Reference model: buffered pairs, one outstanding read that may be marked for discard.
  logic [63:0] mq[$];
  bit          m_busy;
  bit          m_doomed;
  logic [31:0] m_pend;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_busy   = 1'b0;
    m_doomed = 1'b0;
    m_pend   = '0;
  endtask

  // One cycle: drive, check combinational/head outputs, clock, advance model.
  task automatic step(input logic ce, input logic [31:0] pc, input logic g, input logic rv,
                      input logic [31:0] rdata, input logic f, input logic rdy);
    bit rsp, slot, ereq, egrant, was_busy;
    ce_i = ce; pc_i = pc; mem_gnt_i = g; mem_rvalid_i = rv;
    mem_rdata_i = rdata; flush_i = f; id_ready_i = rdy;
    #1;
    rsp    = m_busy && !m_doomed && rv;
    slot   = (mq.size() + (rsp ? 1 : 0)) < DEPTH;
    ereq   = ce && !f && slot && (!m_busy || rsp);
    egrant = ereq && g;
    chk("mem_req", 64'(mem_req_o), 64'(ereq));
    chk("pc_ready", 64'(pc_ready_o), 64'(egrant));
    chk("mem_addr", 64'(mem_addr_o), 64'(pc));
    chk("id_valid", 64'(id_valid_o), 64'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("id_pc", 64'(id_pc_o), 64'(mq[0][63:32]));
      chk("id_inst", 64'(id_inst_o), 64'(mq[0][31:0]));
    end
    if (pc_ready_o) n_ready++;
    if (id_valid_o && id_inst_o == 32'hDEADBEEF) seen_dead = 1'b1;
    @(posedge clk);
    was_busy = m_busy;
    if (f) begin
      mq.delete();
      if (m_busy && rv) begin m_busy = 1'b0; m_doomed = 1'b0; end
      else if (m_busy)  m_doomed = 1'b1;
    end else begin
      if (mq.size() != 0 && rdy) void'(mq.pop_front());
      if (rsp) mq.push_back({m_pend, rdata});
      if (was_busy) begin
        if (m_doomed) begin
          if (rv) begin m_busy = 1'b0; m_doomed = 1'b0; end
        end else if (rv) begin
          m_busy = egrant;
        end
      end else begin
        m_busy = egrant;
      end
    end
    if (egrant) m_pend = pc;
    @(negedge clk);
  endtask

  initial begin
    // Reset with ce high: request must still be suppressed
    rst = 1'b1; ce_i = 1'b1; pc_i = 32'h40; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b0;
    mem_rdata_i = '0; flush_i = 1'b0; id_ready_i = 1'b0;
    model_reset();
    @(negedge clk); @(negedge clk);
    chk("rst_id_valid", 64'(id_valid_o), 64'h0);
    chk("rst_id_pc", 64'(id_pc_o), 64'h0);
    chk("rst_id_inst", 64'(id_inst_o), 64'h0);
    chk("rst_mem_req", 64'(mem_req_o), 64'h0);
    chk("rst_pc_ready", 64'(pc_ready_o), 64'h0);
    rst = 1'b0;

    // Streaming fetch 0x0, 0x4, 0x8 with single-cycle latency
    step(1, 32'h0, 1, 0, 32'h0, 0, 1);
    step(1, 32'h4, 1, 1, 32'hA0000000, 0, 1);
    chk("seq_first_valid", 64'(id_valid_o), 64'h1);
    chk("seq_first_pc", 64'(id_pc_o), 64'h0);
    step(1, 32'h8, 1, 1, 32'hA0000004, 0, 1);
    chk("seq_second_pc", 64'(id_pc_o), 64'h4);
    step(0, 32'hC, 0, 1, 32'hA0000008, 0, 1);
    chk("seq_third_pc", 64'(id_pc_o), 64'h8);
    chk("seq_third_inst", 64'(id_inst_o), 64'hA0000008);
    step(0, 32'hC, 0, 0, 32'h0, 0, 1);

    // Fill with decode stalled: exactly DEPTH grants
    n_ready = 0;
    for (int i = 0; i < 8; i++)
      step(1, 32'h1000 + 32'(i*4), 1, 1, 32'hB0000000 + 32'(i), 0, 0);
    chk("fill_grants", 64'(n_ready), 64'(DEPTH));
    chk("fill_req_low", 64'(mem_req_o), 64'h0);
    step(1, 32'h2000, 1, 0, 32'h0, 0, 1);
    step(1, 32'h2000, 1, 0, 32'h0, 0, 0);
    step(1, 32'h2004, 0, 1, 32'hB1, 0, 0);
    step(0, 32'h0, 0, 0, 32'h0, 1, 0);
    step(0, 32'h0, 0, 0, 32'h0, 0, 0);

    // Flush while waiting; late response discarded three cycles later
    step(1, 32'h200, 1, 0, 32'h0, 0, 1);
    step(1, 32'h204, 1, 0, 32'h0, 1, 1);
    chk("flush_valid_low", 64'(id_valid_o), 64'h0);
    step(1, 32'h100, 1, 0, 32'h0, 0, 1);
    step(1, 32'h100, 1, 0, 32'h0, 0, 1);
    step(1, 32'h100, 1, 1, 32'hDEADBEEF, 0, 1);
    step(1, 32'h100, 1, 0, 32'h0, 0, 1);
    step(0, 32'h104, 0, 1, 32'h11111111, 0, 0);
    chk("after_flush_pc", 64'(id_pc_o), 64'h100);
    chk("after_flush_inst", 64'(id_inst_o), 64'h11111111);
    step(0, 32'h0, 0, 0, 32'h0, 0, 1);
    chk("no_deadbeef", 64'(seen_dead), 64'h0);

    // Flush coinciding with response and pop
    step(1, 32'h300, 1, 0, 32'h0, 0, 0);
    step(1, 32'h304, 1, 1, 32'hC0, 0, 0);
    step(1, 32'h308, 1, 1, 32'hC4, 1, 1);
    chk("flush_rsp_empty", 64'(id_valid_o), 64'h0);
    step(1, 32'h400, 0, 0, 32'h0, 0, 1);

    // Async reset mid-WAIT with two entries buffered
    step(1, 32'h500, 1, 0, 32'h0, 0, 0);
    step(1, 32'h504, 1, 1, 32'hD0, 0, 0);
    step(1, 32'h508, 1, 1, 32'hD4, 0, 0);
    chk("pre_rst_valid", 64'(id_valid_o), 64'h1);
    ce_i = 1'b1; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_id_valid", 64'(id_valid_o), 64'h0);
    chk("arst_id_pc", 64'(id_pc_o), 64'h0);
    chk("arst_id_inst", 64'(id_inst_o), 64'h0);
    chk("arst_mem_req", 64'(mem_req_o), 64'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(0, 32'h600, 0, 1, 32'hE0, 0, 1);
    step(0, 32'h600, 0, 0, 32'h0, 0, 1);

    // Grant withheld for five cycles
    n_ready = 0;
    for (int i = 0; i < 5; i++)
      step(1, 32'h700 + 32'(i*4), 0, 0, 32'h0, 0, 1);
    chk("nogrant_ready", 64'(n_ready), 64'h0);
    chk("nogrant_valid", 64'(id_valid_o), 64'h0);

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 2) != 0), $urandom, 1'($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 2) != 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
